// File: rtl/fifo_rd_adapter_pkg.sv
// Shared types and constants for the FIFO read adapter.
// The occupancy state enum doubles as the buffered word count.
package fifo_rd_adapter_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_e;

  function automatic logic [1:0] occ_of(input occ_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry word store for the FIFO read adapter: write at tail, read at head.
// The head entry is driven straight from registers, so rd_data_o has no path from wr_data_i.
module fifo_rd_skid_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[tail_q] <= wr_data_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (rd_en_i) head_q <= head_q + 1'b1;
    end
  end

  assign rd_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a 1-cycle-latency FIFO read port into a valid/ready stream with a 2-word buffer.
// Optional FIFO_RD_ADAPTER_STATS_EN adds beat_cnt (wrapping) and stall_cnt (saturating).
//
// state   | meaning
// S_EMPTY | no buffered word, m_valid=0
// S_ONE   | one buffered word
// S_TWO   | buffer full
module fifo_rd_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPTER_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  import fifo_rd_adapter_pkg::*;

  occ_state_e state_q, state_d;
  logic       infl_q, infl_d;
  logic [1:0] occ;
  logic       drain;
  logic       capture;

  assign occ     = occ_of(state_q);
  assign m_valid = (state_q != S_EMPTY);
  assign drain   = m_valid && m_ready;
  // A word arriving during a flush cycle is dropped rather than stored.
  assign capture = infl_q && !flush;

  // occ + infl - drain < 2, rearranged to avoid a subtraction; rst_n gating keeps pops off during reset.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush &&
                      (({1'b0, occ} + {2'b00, infl_q}) < (3'd2 + {2'b00, drain}));

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    infl_d  = fifo_rd_en;
    if (flush) begin
      state_d = S_EMPTY;
      infl_d  = 1'b0;
    end else if (capture && !drain) begin
      case (state_q)
        S_EMPTY: state_d = S_ONE;
        default: state_d = S_TWO;
      endcase
    end else if (!capture && drain) begin
      case (state_q)
        S_TWO:   state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .wr_en_i   (capture),
    .wr_data_i (fifo_dout),
    .rd_en_i   (drain),
    .rd_data_o (m_data)
  );

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (drain) beat_cnt_q <= beat_cnt_q + 32'd1;
      if (m_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Self-checking bench for fifo_rd_adapter: a cycle table plus directed multi-cycle sequences.
module tb_fifo_rd_adapter;

  localparam int DW = 32;

  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cnt;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int delivered;
  int pops;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb[$];

  typedef struct {
    int            npush;
    logic          rdy;
    logic          fl;
    logic          exp_valid;
    logic          exp_rd_en;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample just after the negedge, scoreboard drains/pops, advance to next negedge.
  task automatic step();
    logic will_pop;
    #1;
    will_pop = fifo_rd_en && !fifo_empty;
    if (fifo_empty) chk("rd_en_when_empty", DW'(fifo_rd_en), '0);
    if (flush)      chk("rd_en_during_flush", DW'(fifo_rd_en), '0);
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_order actual=%h required=<no word outstanding>", m_data);
      end else begin
        chk("drain_order", m_data, sb.pop_front());
      end
      delivered++;
    end
    if (will_pop) begin
      sb.push_back(fifo_q[0]);
      pops++;
    end
    if (flush || !rst_n) sb.delete();
    chk("outstanding_le2", DW'(sb.size() <= 2), DW'(1));
    @(posedge rd_clk);
    @(negedge rd_clk);
    if (will_pop) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rst_n      = 1'b0;
    m_ready    = 1'b0;
    flush      = 1'b0;
    fifo_q.delete();
    sb.delete();
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    repeat (2) @(negedge rd_clk);
    rst_n      = 1'b1;
    delivered  = 0;
    pops       = 0;
  endtask

  initial begin
    int wcnt;
    int gaps;
    int cyc;
    int bursts;
    logic seen;
    logic first;

    rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0;
    fifo_empty = 1'b1; fifo_dout = '0;
    delivered = 0; pops = 0;

    // Reset state, including a non-empty FIFO that must not be popped under reset.
    #1;
    chk("rst_valid", DW'(m_valid), '0);
    chk("rst_data", m_data, '0);
    push(32'hDEAD_0000);
    #1;
    chk("rst_rd_en", DW'(fifo_rd_en), '0);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    chk("rst_beat_cnt", beat_cnt, '0);
    chk("rst_stall_cnt", stall_cnt, '0);
`endif

    // Cycle table: npush, m_ready, flush, exp m_valid, exp fifo_rd_en, exp m_data.
    tbl[0]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100};
    tbl[4]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100};
    tbl[5]  = '{0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100};
    tbl[6]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h101};
    tbl[7]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102};
    tbl[8]  = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h102};
    tbl[9]  = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h102};
    tbl[10] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[11] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104};
    tbl[13] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    do_reset();
    wcnt = 0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].npush; k++) begin
        push(32'h100 + 32'(wcnt));
        wcnt++;
      end
      m_ready = tbl[i].rdy;
      flush   = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_valid", i), DW'(m_valid), DW'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_rd_en", i), DW'(fifo_rd_en), DW'(tbl[i].exp_rd_en));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), m_data, tbl[i].exp_data);
      step();
    end
    flush = 1'b0;

    // Streaming: 64 words, continuous valid after the first.
    do_reset();
    for (int i = 0; i < 64; i++) push(32'h1A2B_0000 + 32'(i));
    m_ready = 1'b1;
    gaps = 0; cyc = 0; seen = 1'b0;
    while (delivered < 64 && cyc < 300) begin
      #1;
      if (seen && !m_valid) gaps++;
      if (m_valid) seen = 1'b1;
      step();
      cyc++;
    end
    chk("stream_delivered", 32'(delivered), 32'd64);
    chk("stream_gaps", 32'(gaps), 32'd0);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    chk("stream_beat_cnt", beat_cnt, 32'd64);
`endif

    // Backpressure: two pops, head held stable for 20 stalled cycles, then ordered drain.
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hB000_0000 + 32'(i));
    m_ready = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp_valid", DW'(m_valid), DW'(1));
      chk("bp_data", m_data, 32'hB000_0000);
      step();
    end
    chk("bp_pops", 32'(pops), 32'd2);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    chk("bp_stall_cnt", stall_cnt, 32'd20);
`endif
    m_ready = 1'b1;
    cyc = 0;
    while (delivered < 8 && cyc < 50) begin step(); cyc++; end
    chk("bp_delivered", 32'(delivered), 32'd8);

    // Random ready with the FIFO refilled in bursts of 16.
    do_reset();
    bursts = 0; cyc = 0;
    while (delivered < 64 && cyc < 3000) begin
      if (fifo_q.size() == 0 && bursts < 4) begin
        for (int k = 0; k < 16; k++) push(32'hC000_0000 + 32'(bursts * 16 + k));
        bursts++;
      end
      m_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("rand_delivered", 32'(delivered), 32'd64);

    // Flush with one buffered and one in-flight word.
    do_reset();
    push(32'h5500_0000); push(32'h5500_0001); push(32'h5500_0002);
    m_ready = 1'b0;
    repeat (2) step();
    flush = 1'b1;
    #1;
    chk("flush_pre_valid", DW'(m_valid), DW'(1));
    step();
    flush = 1'b0;
    #1;
    chk("flush_valid_after", DW'(m_valid), '0);
    m_ready = 1'b1;
    cyc = 0;
    while (delivered == 0 && cyc < 20) begin
      #1;
      if (m_valid) chk("flush_next_word", m_data, 32'h5500_0002);
      step();
      cyc++;
    end
    chk("flush_delivered", 32'(delivered), 32'd1);

    // Asynchronous reset with two buffered words.
    do_reset();
    for (int i = 0; i < 10; i++) push(32'hD000_0000 + 32'(i));
    m_ready = 1'b0;
    repeat (4) step();
    #1;
    chk("mid_pre_valid", DW'(m_valid), DW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(m_valid), '0);
    chk("mid_rst_data", m_data, '0);
    chk("mid_rst_rd_en", DW'(fifo_rd_en), '0);
    step();
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    delivered = 0;
    first = 1'b1;
    cyc = 0;
    while (delivered < 8 && cyc < 50) begin
      #1;
      if (first && m_valid) begin
        chk("mid_first_word", m_data, 32'hD000_0002);
        first = 1'b0;
      end
      step();
      cyc++;
    end
    chk("mid_delivered", 32'(delivered), 32'd8);

    // FIFO empty for 10 cycles between words.
    do_reset();
    push(32'hE000_0000);
    m_ready = 1'b1;
    cyc = 0;
    while (delivered < 1 && cyc < 10) begin step(); cyc++; end
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("empty_rd_en", DW'(fifo_rd_en), '0);
      chk("empty_valid", DW'(m_valid), '0);
      step();
    end
    push(32'hE000_0001);
    cyc = 0;
    while (delivered < 2 && cyc < 10) begin step(); cyc++; end
    chk("empty_delivered", 32'(delivered), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
